// File: rtl/refill_arbiter.sv
// Round-robin arbiter sharing one line-refill memory read port between
// the instruction cache (requester 0) and the data cache (requester 1).
module refill_arbiter #(
  parameter int LineSize       = 128,
  parameter int ByteOffsetBits = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req0_read_en_i,
  input  logic [31:0]         req0_addr_i,
  output logic                req0_valid_o,
  output logic [LineSize-1:0] req0_data_o,
  input  logic                req1_read_en_i,
  input  logic [31:0]         req1_addr_i,
  output logic                req1_valid_o,
  output logic [LineSize-1:0] req1_data_o,
  output logic [31:0]         mem_addr_o,
  output logic                mem_read_en_o,
  input  logic                mem_read_valid_i,
  input  logic [LineSize-1:0] mem_read_data_i
);

  // state | meaning
  // IDLE  | waiting for a request; arbitrates and latches the line address
  // BUSY  | memory read in flight; waits for mem_read_valid_i
  // RESP  | one-cycle valid pulse to the granted requester (unless aborted)
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [31:0] AlignMask = ~((32'd1 << ByteOffsetBits) - 32'd1);

  state_t              state;
  logic                grant_id;
  logic                last_grant;
  logic                aborted;
  logic [31:0]         addr_q;
  logic [LineSize-1:0] data_q;

  logic        pick;
  logic        granted_en;
  logic [31:0] pick_addr;

  always_comb begin
    pick       = (req0_read_en_i && req1_read_en_i) ? ~last_grant : req1_read_en_i;
    pick_addr  = pick ? req1_addr_i : req0_addr_i;
    granted_en = grant_id ? req1_read_en_i : req0_read_en_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      grant_id      <= 1'b0;
      last_grant    <= 1'b1;
      aborted       <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      mem_read_en_o <= 1'b0;
      req0_valid_o  <= 1'b0;
      req1_valid_o  <= 1'b0;
    end else begin
      req0_valid_o <= 1'b0;
      req1_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_read_en_i || req1_read_en_i) begin
            grant_id      <= pick;
            last_grant    <= pick;
            addr_q        <= pick_addr & AlignMask;
            aborted       <= 1'b0;
            mem_read_en_o <= 1'b1;
            state         <= BUSY;
          end
        end
        BUSY: begin
          // A drop at any BUSY edge, including the capture edge, cancels the pulse.
          if (!granted_en) aborted <= 1'b1;
          if (mem_read_valid_i) begin
            data_q        <= mem_read_data_i;
            mem_read_en_o <= 1'b0;
            state         <= RESP;
            if (!aborted && granted_en) begin
              if (grant_id) req1_valid_o <= 1'b1;
              else          req0_valid_o <= 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_addr_o  = addr_q;
  assign req0_data_o = data_q;
  assign req1_data_o = data_q;

endmodule
